// File: rtl/lcd_scanout.sv
// Raster scan-out of a 96x64 monochrome display RAM into a valid/ready pixel stream.
// Optional start-line scroll offset is built only when LCD_SCANOUT_START_LINE_EN is defined.
module lcd_scanout (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  input  logic        display_enabled,
  input  logic        all_pixels_on,
  input  logic        invert_pixels,
  input  logic        row_order,
  input  logic [5:0]  start_line,
  output logic [10:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [6:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic        pix_on
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

  state_t     state_q, state_d;
  logic [6:0] x_q, x_d;
  logic [5:0] y_q, y_d;
  logic       pix_on_q, pix_on_d;
  logic       enabled_q, enabled_d;
  logic       all_on_q, all_on_d;
  logic       invert_q, invert_d;
  logic       flip_q, flip_d;
  logic [5:0] src;
  logic [5:0] eff;

`ifdef LCD_SCANOUT_START_LINE_EN
  logic [5:0] start_line_q, start_line_d;

  always_ff @(posedge clk) begin
    if (reset) start_line_q <= '0;
    else       start_line_q <= start_line_d;
  end

  always_comb begin
    start_line_d = start_line_q;
    if (state_q == IDLE && frame_start) start_line_d = start_line;
  end

  always_comb begin
    src = flip_q ? (6'd63 - y_q) : y_q;
    eff = src + start_line_q;  // 6-bit wrap gives the mod-64 scroll
  end
`else
  logic unused_start_line;
  assign unused_start_line = ^start_line;

  always_comb begin
    src = flip_q ? (6'd63 - y_q) : y_q;
    eff = src;
  end
`endif

  // Byte address: each 8-line page occupies 132 bytes of RAM, column picks the byte.
  assign mem_addr = ({8'd0, eff[5:3]} * 11'd132) + {4'd0, x_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      pix_on_q  <= 1'b0;
      enabled_q <= 1'b0;
      all_on_q  <= 1'b0;
      invert_q  <= 1'b0;
      flip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pix_on_q  <= pix_on_d;
      enabled_q <= enabled_d;
      all_on_q  <= all_on_d;
      invert_q  <= invert_d;
      flip_q    <= flip_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    pix_on_d  = pix_on_q;
    enabled_d = enabled_q;
    all_on_d  = all_on_q;
    invert_d  = invert_q;
    flip_d    = flip_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          enabled_d = display_enabled;
          all_on_d  = all_pixels_on;
          invert_d  = invert_pixels;
          flip_d    = row_order;
          x_d       = '0;
          y_d       = '0;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        if (!enabled_q)    pix_on_d = 1'b0;
        else if (all_on_q) pix_on_d = 1'b1;
        else               pix_on_d = mem_data[eff[2:0]] ^ invert_q;
        state_d = EMIT;
      end
      EMIT: begin
        if (pix_ready) begin
          if (x_q == 7'd95) begin
            x_d     = '0;
            y_d     = y_q + 6'd1;
            state_d = (y_q == 6'd63) ? DONE : FETCH;
          end else begin
            x_d     = x_q + 7'd1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign pix_valid  = (state_q == EMIT);
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_on     = pix_on_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Directed bench for lcd_scanout: RAM model, full-frame scans with hand-computed lit/dark pixels.
module tb_lcd_scanout;

  logic        clk = 1'b0;
  logic        reset, frame_start, busy, frame_done;
  logic        display_enabled, all_pixels_on, invert_pixels, row_order;
  logic [5:0]  start_line;
  logic [10:0] mem_addr;
  logic [7:0]  mem_data;
  logic        pix_valid, pix_ready, pix_on;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;

  logic [7:0]  ram [0:2047];

  int checks = 0;
  int errors = 0;

  int n_pix, n_lit, n_dark, order_err, stab_err, gap_err, done_cnt, first_lat, timeout;
  int lit_x [4];
  int lit_y [4];
  int dark_x [4];
  int dark_y [4];
  int stop_x, stop_y, post_busy, post_valid, post_x, post_y, post_done;

  always #5 clk = ~clk;

  always_ff @(posedge clk) mem_data <= ram[mem_addr];

  lcd_scanout dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .display_enabled(display_enabled), .all_pixels_on(all_pixels_on),
    .invert_pixels(invert_pixels), .row_order(row_order), .start_line(start_line),
    .mem_addr(mem_addr), .mem_data(mem_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_on(pix_on)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic set_cfg(input bit en, input bit all_on, input bit inv, input bit flip,
                         input logic [5:0] sl);
    display_enabled = en;
    all_pixels_on   = all_on;
    invert_pixels   = inv;
    row_order       = flip;
    start_line      = sl;
  endtask

  // One frame; rnd stalls pix_ready, disturb pokes frame_start/config mid-frame,
  // stop_at >= 0 asserts reset while that pixel index is on offer.
  task automatic run_frame(input bit rnd, input bit disturb, input int stop_at);
    int cyc, last_acc, ex, ey, hx, hy, hon;
    bit prev_valid, stalled, poked;
    n_pix = 0; n_lit = 0; n_dark = 0; order_err = 0; stab_err = 0; gap_err = 0;
    done_cnt = 0; first_lat = -1; timeout = 0;
    cyc = 0; last_acc = 0; ex = 0; ey = 0; hx = 0; hy = 0; hon = 0;
    prev_valid = 0; stalled = 0; poked = 0;
    frame_start = 1'b1;
    pix_ready   = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      frame_start = 1'b0;
      if (cyc > 30000) begin
        timeout = 1;
        break;
      end
      if (frame_done) done_cnt++;
      if (stalled && (!pix_valid || pix_x !== hx[6:0] || pix_y !== hy[5:0] || pix_on !== hon[0]))
        stab_err++;
      if (pix_valid && !prev_valid) begin
        if (first_lat < 0) first_lat = cyc;
        else if (cyc - last_acc != 3) gap_err++;
      end
      prev_valid = pix_valid;
      if (stop_at >= 0 && pix_valid && n_pix == stop_at) begin
        stop_x = pix_x;
        stop_y = pix_y;
        reset  = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        post_busy  = busy;
        post_valid = pix_valid;
        post_x     = pix_x;
        post_y     = pix_y;
        return;
      end
      if (n_pix == 6144 && !busy) break;
      if (disturb && !poked && n_pix == 100 && pix_valid) begin
        poked = 1;
        frame_start = 1'b1;
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 6'd5);
      end
      pix_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (pix_valid && pix_ready) begin
        if (pix_x !== ex[6:0] || pix_y !== ey[5:0]) order_err++;
        if (pix_on) begin
          if (n_lit < 4) begin lit_x[n_lit] = pix_x; lit_y[n_lit] = pix_y; end
          n_lit++;
        end else begin
          if (n_dark < 4) begin dark_x[n_dark] = pix_x; dark_y[n_dark] = pix_y; end
          n_dark++;
        end
        n_pix++;
        last_acc = cyc;
        if (ex == 95) begin ex = 0; ey++; end
        else ex++;
      end
      stalled = pix_valid && !pix_ready;
      hx = pix_x; hy = pix_y; hon = pix_on;
    end
  endtask

  task automatic frame_checks(input string tag, input int exp_pix, input int exp_done);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_pixels"}, n_pix, exp_pix);
    check({tag, "_frame_done"}, done_cnt, exp_done);
    check({tag, "_order_err"}, order_err, 0);
    check({tag, "_stall_err"}, stab_err, 0);
    check({tag, "_gap_err"}, gap_err, 0);
    check({tag, "_first_latency"}, first_lat, 3);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    ram[0] = 8'h01;
    reset = 1'b1; frame_start = 1'b0; pix_ready = 1'b0;
    set_cfg(1'b1, 1'b1, 1'b1, 1'b1, 6'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_on", pix_on, 0);
    check("rst_mem_addr", mem_addr, 0);

    // Single lit bit at byte 0 -> only (0,0)
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    run_frame(1'b0, 1'b0, -1);
    frame_checks("basic", 6144, 1);
    check("basic_lit", n_lit, 1);
    check("basic_lit_x", lit_x[0], 0);
    check("basic_lit_y", lit_y[0], 0);

    // Flip + invert with random stalls and mid-frame pokes; byte 929 bit7 and byte 0 bit0 go dark
    ram[7*132+5] = 8'h80;
    set_cfg(1'b1, 1'b0, 1'b1, 1'b1, 6'd0);
    run_frame(1'b1, 1'b1, -1);
    frame_checks("flipinv", 6144, 1);
    check("flipinv_lit", n_lit, 6142);
    check("flipinv_dark0_x", dark_x[0], 5);
    check("flipinv_dark0_y", dark_y[0], 0);
    check("flipinv_dark1_x", dark_x[1], 0);
    check("flipinv_dark1_y", dark_y[1], 63);

    // Scroll by one line
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 6'd1);
    run_frame(1'b0, 1'b0, -1);
    frame_checks("scroll", 6144, 1);
    check("scroll_lit", n_lit, 2);
`ifdef LCD_SCANOUT_START_LINE_EN
    check("scroll_lit0_x", lit_x[0], 5);
    check("scroll_lit0_y", lit_y[0], 62);
    check("scroll_lit1_x", lit_x[1], 0);
    check("scroll_lit1_y", lit_y[1], 63);
`else
    check("scroll_lit0_x", lit_x[0], 0);
    check("scroll_lit0_y", lit_y[0], 0);
    check("scroll_lit1_x", lit_x[1], 5);
    check("scroll_lit1_y", lit_y[1], 63);
`endif

    // Display off overrides all-on; reset lands while (40,10) is on offer
    set_cfg(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    run_frame(1'b0, 1'b0, 1000);
    check("intr_timeout", timeout, 0);
    check("intr_stop_x", stop_x, 40);
    check("intr_stop_y", stop_y, 10);
    check("intr_lit", n_lit, 0);
    check("intr_pixels", n_pix, 1000);
    check("intr_post_busy", post_busy, 0);
    check("intr_post_valid", post_valid, 0);
    check("intr_post_x", post_x, 0);
    check("intr_post_y", post_y, 0);
    post_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (frame_done || busy) post_done++;
    end
    check("intr_no_resume", post_done, 0);

    // Restart after reset with all pixels forced on
    set_cfg(1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
    run_frame(1'b0, 1'b0, -1);
    frame_checks("allon", 6144, 1);
    check("allon_lit", n_lit, 6144);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
